// File: rtl/mmio_resp_pkg.sv
// Shared definitions for the MMIO responder: state encodings, decoded strobe
// bundle and the MMIO address map used by mem_ctrl and the benches.
package mmio_resp_pkg;

  // MMIO address map (word addresses at the top of the data space).
  localparam logic [31:0] MMIO_STDOUT_ADDR   = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_HALT_ADDR     = 32'hFFFF_FFF4;
  localparam logic [31:0] MMIO_BP_START_ADDR = 32'hFFFF_FFF8;
  localparam logic [31:0] MMIO_BP_END_ADDR   = 32'hFFFF_FFFC;

  // Byte lane that carries the stdout character.
  localparam int STDOUT_LANE = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } bp_state_t;

  // Store-qualified MMIO strobes, valid only while the core is running.
  typedef struct packed {
    logic push;
    logic halt;
    logic start;
    logic stop;
  } mmio_hit_t;

endpackage

// File: rtl/mmio_resp_sync_fifo.sv
// Plain synchronous FIFO with extra-MSB pointers. The caller must not push
// while full unless it pops in the same cycle; there is no drop logic here.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int aw = $clog2(depth);

  logic [aw:0]      wr_ptr;
  logic [aw:0]      rd_ptr;
  logic [width-1:0] mem [depth];

  // Advance read and write pointers; they wrap modulo 2*depth.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (aw + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (aw + 1)'(1);
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is not reset; emptiness comes from the pointers, so stale contents are never observed.
    if (push) mem[wr_ptr[aw-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[aw-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);

endmodule

// File: rtl/mmio_resp.sv
// MMIO responder on the MEM stage: buffers stdout bytes for the host,
// sequences halt behind the stdout drain, and counts branch outcomes
// inside a software-delimited window.
module mmio_resp
  import mmio_resp_pkg::*;
#(
  parameter int word_width   = 32,
  parameter int stdout_depth = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_wren,
  input  logic                  stdout_en,
  input  logic                  halt_en,
  input  logic                  start_bp_count,
  input  logic                  end_bp_count,
  input  logic [3:0]            which_bytes,
  input  logic [word_width-1:0] mem_data_in,
  input  logic                  br_resolved,
  input  logic                  br_mispredict,
  input  logic                  stdout_ready,
  output logic                  stdout_valid,
  output logic [7:0]            stdout_byte,
  output logic                  stdout_overflow,
  output logic                  halted,
  output logic                  halt_pending,
  output logic [word_width-1:0] bp_total,
  output logic [word_width-1:0] bp_miss,
  output logic                  bp_done
);

  halt_state_t halt_state;
  bp_state_t   bp_state;
  mmio_hit_t   hit;

  logic       running;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_rdata;
  logic       unused_bits;

  // Only byte lane 0 carries stdout data; the rest of the store is ignored.
  assign unused_bits = ^{mem_data_in[word_width-1:8], which_bytes[3:1]};

  // Once a halt has been seen, no new MMIO side effects are accepted.
  assign running   = (halt_state == RUN);
  assign hit.push  = running && mem_wren && stdout_en && which_bytes[STDOUT_LANE];
  assign hit.halt  = running && mem_wren && halt_en;
  assign hit.start = running && mem_wren && start_bp_count;
  assign hit.stop  = running && mem_wren && end_bp_count;

  assign stdout_valid = !fifo_empty;
  assign fifo_pop     = stdout_valid && stdout_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign fifo_push    = hit.push && (!fifo_full || fifo_pop);
  // The FIFO head may be stale memory when empty; present zero instead.
  assign stdout_byte  = stdout_valid ? fifo_rdata : 8'h00;

  sync_fifo #(
    .width (8),
    .depth (stdout_depth)
  ) u_stdout_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (mem_data_in[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  function automatic logic [word_width-1:0] sat_inc(input logic [word_width-1:0] v);
    return (&v) ? v : v + word_width'(1);
  endfunction

  // Sticky flag for a byte that arrived with the FIFO full and no pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stdout_overflow <= 1'b0;
    end else if (hit.push && fifo_full && !fifo_pop) begin
      stdout_overflow <= 1'b1;
    end
  end

  // Halt sequencer: freeze fetch on a halt store, report halted once stdout is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_state   <= RUN;
      halt_pending <= 1'b0;
      halted       <= 1'b0;
    end else begin
      case (halt_state)
        RUN: begin
          if (hit.halt) begin
            halt_state   <= DRAIN;
            halt_pending <= 1'b1;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            halt_state   <= HALTED;
            halt_pending <= 1'b0;
            halted       <= 1'b1;
          end
        end
        HALTED: begin
          halt_state <= HALTED;
        end
        default: begin
          halt_state   <= RUN;
          halt_pending <= 1'b0;
          halted       <= 1'b0;
        end
      endcase
    end
  end

  // Branch-predictor window: start clears and opens, end freezes the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_state <= IDLE;
      bp_total <= '0;
      bp_miss  <= '0;
      bp_done  <= 1'b0;
    end else if (hit.start) begin
      // Start dominates end and any branch resolving in the same cycle.
      bp_state <= COUNT;
      bp_total <= '0;
      bp_miss  <= '0;
      bp_done  <= 1'b0;
    end else begin
      case (bp_state)
        IDLE: begin
          bp_state <= IDLE;
        end
        COUNT: begin
          if (br_resolved) begin
            bp_total <= sat_inc(bp_total);
            if (br_mispredict) bp_miss <= sat_inc(bp_miss);
          end
          if (hit.stop) begin
            bp_state <= DONE;
            bp_done  <= 1'b1;
          end
        end
        DONE: begin
          bp_state <= DONE;
        end
        default: begin
          bp_state <= IDLE;
          bp_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_resp.sv
// Bench for mmio_resp: a vector table for single-cycle behaviour, directed
// sequences for overflow, halt, window counting, saturation and async reset,
// and a random run checked against a queue-based reference model.
module tb_mmio_resp;

  localparam int W = 8;   // narrow counters so saturation is reachable
  localparam int D = 16;
  localparam int SAT = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         mem_wren;
  logic         stdout_en;
  logic         halt_en;
  logic         start_bp_count;
  logic         end_bp_count;
  logic [3:0]   which_bytes;
  logic [W-1:0] mem_data_in;
  logic         br_resolved;
  logic         br_mispredict;
  logic         stdout_ready;
  logic         stdout_valid;
  logic [7:0]   stdout_byte;
  logic         stdout_overflow;
  logic         halted;
  logic         halt_pending;
  logic [W-1:0] bp_total;
  logic [W-1:0] bp_miss;
  logic         bp_done;

  mmio_resp #(
    .word_width   (W),
    .stdout_depth (D)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_wren        (mem_wren),
    .stdout_en       (stdout_en),
    .halt_en         (halt_en),
    .start_bp_count  (start_bp_count),
    .end_bp_count    (end_bp_count),
    .which_bytes     (which_bytes),
    .mem_data_in     (mem_data_in),
    .br_resolved     (br_resolved),
    .br_mispredict   (br_mispredict),
    .stdout_ready    (stdout_ready),
    .stdout_valid    (stdout_valid),
    .stdout_byte     (stdout_byte),
    .stdout_overflow (stdout_overflow),
    .halted          (halted),
    .halt_pending    (halt_pending),
    .bp_total        (bp_total),
    .bp_miss         (bp_miss),
    .bp_done         (bp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_checks = 0;
  int bad_checks   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad_checks++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_wren       = 1'b0;
    stdout_en      = 1'b0;
    halt_en        = 1'b0;
    start_bp_count = 1'b0;
    end_bp_count   = 1'b0;
    which_bytes    = 4'h0;
    mem_data_in    = '0;
    br_resolved    = 1'b0;
    br_mispredict  = 1'b0;
    stdout_ready   = 1'b0;
  endtask

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic store_byte(input logic [7:0] b);
    mem_wren    = 1'b1;
    stdout_en   = 1'b1;
    which_bytes = 4'h1;
    mem_data_in = W'(b);
    tick();
    mem_wren    = 1'b0;
    stdout_en   = 1'b0;
    which_bytes = 4'h0;
  endtask

  task automatic store_ctl(input logic h, input logic s, input logic e);
    mem_wren       = 1'b1;
    halt_en        = h;
    start_bp_count = s;
    end_bp_count   = e;
    tick();
    mem_wren       = 1'b0;
    halt_en        = 1'b0;
    start_bp_count = 1'b0;
    end_bp_count   = 1'b0;
  endtask

  typedef struct {
    logic       wren, sen, hen, st, en;
    logic [3:0] wb;
    logic [7:0] data;
    logic       br, mis, rdy;
    logic       e_valid;
    logic [7:0] e_byte;
    logic [7:0] e_total, e_miss;
    logic       e_done;
  } vec_t;

  vec_t vecs [14];

  // Reference model state for the random phase.
  logic [7:0] q [$];
  bit m_ovf, m_drain, m_halted, m_open, m_done;
  int m_total, m_miss;

  initial begin
    int n;
    rst_n = 1'b0;
    idle_inputs();

    // ---------------- reset state ----------------
    do_reset();
    check("rst valid",    32'(stdout_valid), 0);
    check("rst byte",     32'(stdout_byte), 0);
    check("rst overflow", 32'(stdout_overflow), 0);
    check("rst halted",   32'(halted), 0);
    check("rst pending",  32'(halt_pending), 0);
    check("rst total",    32'(bp_total), 0);
    check("rst miss",     32'(bp_miss), 0);
    check("rst done",     32'(bp_done), 0);

    // ---------------- vector table ----------------
    //            wren sen hen st en wb     data   br mis rdy  valid byte   tot mis done
    vecs[0]  = '{0, 1, 0, 0, 0, 4'h1, 8'h55, 0, 0, 1,  0, 8'h00, 0, 0, 0}; // load: no push
    vecs[1]  = '{1, 1, 0, 0, 0, 4'h1, 8'h41, 0, 0, 1,  1, 8'h41, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 0, 0, 4'h1, 8'h42, 0, 0, 1,  1, 8'h42, 0, 0, 0};
    vecs[3]  = '{1, 1, 0, 0, 0, 4'h1, 8'h43, 0, 0, 1,  1, 8'h43, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 4'h0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 0};
    vecs[5]  = '{1, 1, 0, 0, 0, 4'h2, 8'h77, 0, 0, 1,  0, 8'h00, 0, 0, 0}; // lane 0 off
    vecs[6]  = '{1, 0, 0, 1, 0, 4'h0, 8'h00, 1, 1, 1,  0, 8'h00, 0, 0, 0}; // start: branch not counted
    vecs[7]  = '{0, 0, 0, 0, 0, 4'h0, 8'h00, 1, 1, 1,  0, 8'h00, 1, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 4'h0, 8'h00, 1, 0, 1,  0, 8'h00, 2, 1, 0};
    vecs[9]  = '{1, 0, 0, 0, 1, 4'h0, 8'h00, 1, 1, 1,  0, 8'h00, 3, 2, 1}; // end: branch counted
    vecs[10] = '{0, 0, 0, 0, 0, 4'h0, 8'h00, 1, 0, 1,  0, 8'h00, 3, 2, 1}; // frozen
    vecs[11] = '{1, 0, 0, 0, 1, 4'h0, 8'h00, 0, 0, 1,  0, 8'h00, 3, 2, 1}; // end in DONE ignored
    vecs[12] = '{1, 0, 0, 1, 1, 4'h0, 8'h00, 1, 0, 1,  0, 8'h00, 0, 0, 0}; // start wins
    vecs[13] = '{0, 0, 0, 0, 0, 4'h0, 8'h00, 1, 0, 1,  0, 8'h00, 1, 0, 0};

    for (int i = 0; i < 14; i++) begin
      mem_wren       = vecs[i].wren;
      stdout_en      = vecs[i].sen;
      halt_en        = vecs[i].hen;
      start_bp_count = vecs[i].st;
      end_bp_count   = vecs[i].en;
      which_bytes    = vecs[i].wb;
      mem_data_in    = W'(vecs[i].data);
      br_resolved    = vecs[i].br;
      br_mispredict  = vecs[i].mis;
      stdout_ready   = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d valid", i), 32'(stdout_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d byte", i),  32'(stdout_byte),  32'(vecs[i].e_byte));
      check($sformatf("vec%0d total", i), 32'(bp_total),     32'(vecs[i].e_total));
      check($sformatf("vec%0d miss", i),  32'(bp_miss),      32'(vecs[i].e_miss));
      check($sformatf("vec%0d done", i),  32'(bp_done),      32'(vecs[i].e_done));
    end
    idle_inputs();

    // ---------------- window of 10 branches, 4 mispredicted ----------------
    do_reset();
    store_ctl(0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      br_resolved   = 1'b1;
      br_mispredict = (i % 3 == 0);   // i = 0,3,6,9
      tick();
      br_resolved   = 1'b0;
      br_mispredict = 1'b0;
      if (i % 2 == 1) tick();
    end
    store_ctl(0, 0, 1);
    check("win total", 32'(bp_total), 10);
    check("win miss",  32'(bp_miss), 4);
    check("win done",  32'(bp_done), 1);
    br_resolved   = 1'b1;
    br_mispredict = 1'b1;
    repeat (5) tick();
    br_resolved   = 1'b0;
    br_mispredict = 1'b0;
    check("win frozen total", 32'(bp_total), 10);
    check("win frozen miss",  32'(bp_miss), 4);

    // ---------------- saturation ----------------
    do_reset();
    store_ctl(0, 1, 0);
    br_resolved   = 1'b1;
    br_mispredict = 1'b1;
    repeat (SAT + 5) tick();
    br_resolved   = 1'b0;
    br_mispredict = 1'b0;
    check("sat total", 32'(bp_total), SAT);
    check("sat miss",  32'(bp_miss), SAT);

    // ---------------- overflow ----------------
    do_reset();
    for (int i = 0; i < 17; i++) store_byte(8'(8'h10 + i));
    check("ovf flag",  32'(stdout_overflow), 1);
    check("ovf valid", 32'(stdout_valid), 1);
    check("ovf head",  32'(stdout_byte), 32'h10);
    stdout_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 24 && stdout_valid; c++) begin
      check($sformatf("ovf pop%0d", n), 32'(stdout_byte), 32'(8'h10 + n));
      n++;
      tick();
    end
    check("ovf pop count", n, 16);
    check("ovf sticky", 32'(stdout_overflow), 1);
    stdout_ready = 1'b0;

    // ---------------- async reset mid-count ----------------
    do_reset();
    store_byte(8'hAA);
    store_ctl(0, 1, 0);
    br_resolved = 1'b1;
    repeat (5) tick();
    br_resolved = 1'b0;
    check("pre-rst total", 32'(bp_total), 5);
    check("pre-rst valid", 32'(stdout_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async total", 32'(bp_total), 0);
    check("async valid", 32'(stdout_valid), 0);
    check("async byte",  32'(stdout_byte), 0);
    @(negedge clk);
    rst_n = 1'b1;
    store_ctl(0, 0, 1);
    check("end-after-rst done", 32'(bp_done), 0);

    // ---------------- random run against reference model ----------------
    do_reset();
    q.delete();
    m_ovf = 0; m_drain = 0; m_halted = 0; m_open = 0; m_done = 0;
    m_total = 0; m_miss = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      int pre_size;
      bit running, do_pop, s_hit, h_hit, st_hit, en_hit;
      idle_inputs();
      r = $urandom_range(0, 999);
      stdout_en      = (r < 300);
      start_bp_count = (r >= 300 && r < 320);
      end_bp_count   = (r >= 320 && r < 345);
      halt_en        = (r == 999);
      mem_wren       = ($urandom_range(0, 9) < 8);
      which_bytes    = 4'($urandom);
      mem_data_in    = W'($urandom);
      br_resolved    = ($urandom_range(0, 9) < 4);
      br_mispredict  = 1'($urandom);
      stdout_ready   = 1'($urandom);

      running  = !m_drain && !m_halted;
      pre_size = q.size();
      s_hit    = running && mem_wren && stdout_en && which_bytes[0];
      h_hit    = running && mem_wren && halt_en;
      st_hit   = running && mem_wren && start_bp_count;
      en_hit   = running && mem_wren && end_bp_count;

      if (st_hit) begin
        m_total = 0; m_miss = 0; m_open = 1; m_done = 0;
      end else if (m_open) begin
        if (br_resolved) begin
          m_total = (m_total < SAT) ? m_total + 1 : SAT;
          if (br_mispredict) m_miss = (m_miss < SAT) ? m_miss + 1 : SAT;
        end
        if (en_hit) begin
          m_open = 0; m_done = 1;
        end
      end

      do_pop = (pre_size > 0) && stdout_ready;
      if (do_pop) void'(q.pop_front());
      if (s_hit) begin
        if (pre_size < D || do_pop) q.push_back(mem_data_in[7:0]);
        else m_ovf = 1;
      end

      if (m_drain) begin
        if (pre_size == 0) begin
          m_drain = 0; m_halted = 1;
        end
      end else if (!m_halted && h_hit) begin
        m_drain = 1;
      end

      tick();
      check("rnd valid",    32'(stdout_valid), 32'(q.size() > 0));
      check("rnd byte",     32'(stdout_byte), (q.size() > 0) ? 32'(q[0]) : 0);
      check("rnd overflow", 32'(stdout_overflow), 32'(m_ovf));
      check("rnd pending",  32'(halt_pending), 32'(m_drain));
      check("rnd halted",   32'(halted), 32'(m_halted));
      check("rnd total",    32'(bp_total), m_total);
      check("rnd miss",     32'(bp_miss), m_miss);
      check("rnd done",     32'(bp_done), 32'(m_done));
    end
    idle_inputs();

    // ---------------- halt with queued bytes ----------------
    do_reset();
    store_byte(8'h31);
    store_byte(8'h32);
    store_byte(8'h33);
    store_ctl(1, 0, 0);
    check("halt pending", 32'(halt_pending), 1);
    check("halt not yet", 32'(halted), 0);
    repeat (3) tick();
    check("halt holds pending", 32'(halt_pending), 1);
    check("halt holds byte",    32'(stdout_byte), 32'h31);
    stdout_ready = 1'b1;
    repeat (3) tick();
    check("halt drained valid",  32'(stdout_valid), 0);
    check("halt drained halted", 32'(halted), 0);
    tick();
    check("halt halted",   32'(halted), 1);
    check("halt pend off", 32'(halt_pending), 0);
    stdout_ready = 1'b0;
    store_byte(8'h99);
    tick();
    check("halt ignores store", 32'(stdout_valid), 0);
    store_ctl(0, 1, 0);
    check("halt ignores start", 32'(bp_done), 0);
    check("halt stays", 32'(halted), 1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
